// File: rtl/j_txsched.sv
// Two-requester transmit scheduler: round-robin arbiter into a word FIFO,
// drained into a UART transmitter with a post-write hold-off and line-break insertion.
module j_txsched #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [15:0]              dat0,
  input  logic [15:0]              dat1,
  output logic                     ack0,
  output logic                     ack1,
  input  logic                     brk_req,
  input  logic [15:0]              brk_len,
  input  logic                     tbe,
  output logic [15:0]              din,
  output logic                     u2dwr,
  output logic                     txbrk,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     brk_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_BRK
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            ack0_q, ack1_q;
  logic            last_was1;
  logic [15:0]     din_q;
  logic            brk_pend;
  logic [15:0]     brk_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            brk_done_q;

  logic            elig0, elig1, room;
  logic            gnt0, gnt1, push, pop;
  logic [15:0]     push_dat;
  logic            brk_last;

  // A requester still showing its ack is out of this cycle's round;
  // ties go to whichever side did not win last time.
  always_comb begin
    elig0    = req0 & ~ack0_q;
    elig1    = req1 & ~ack1_q;
    room     = (cnt < CW'(DEPTH));
    gnt0     = room & elig0 & (~elig1 | last_was1);
    gnt1     = room & elig1 & (~elig0 | ~last_was1);
    push     = gnt0 | gnt1;
    push_dat = gnt0 ? dat0 : dat1;
    pop      = (state == S_LOAD);
    brk_last = (state == S_BRK) && (brk_cnt == 16'd1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (brk_pend && (cnt == '0) && tbe)
          state_nx = S_BRK;
        else if ((cnt != '0) && tbe)
          state_nx = S_LOAD;
      end
      S_LOAD:  state_nx = (HOLD == 0) ? S_IDLE : S_HOLD;
      S_HOLD:  if (hold_cnt <= HW'(1)) state_nx = S_IDLE;
      S_BRK:   if (brk_last) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!reset && push)
      mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      last_was1  <= 1'b1;
      din_q      <= '0;
      brk_pend   <= 1'b0;
      brk_cnt    <= '0;
      hold_cnt   <= '0;
      brk_done_q <= 1'b0;
    end else begin
      state      <= state_nx;
      ack0_q     <= gnt0;
      ack1_q     <= gnt1;
      brk_done_q <= brk_last;
      if (push) begin
        wr_ptr    <= wr_ptr + 1'b1;
        last_was1 <= gnt1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // Head is captured on LOAD entry; it cannot move until the pop at LOAD exit.
      if (state == S_IDLE && state_nx == S_LOAD)
        din_q <= mem[rd_ptr];
      if (state == S_LOAD)
        hold_cnt <= HW'(HOLD);
      else if (state == S_HOLD)
        hold_cnt <= hold_cnt - 1'b1;
      if (state == S_IDLE && state_nx == S_BRK)
        brk_cnt <= (brk_len == 16'd0) ? 16'd1 : brk_len;
      else if (state == S_BRK)
        brk_cnt <= brk_cnt - 1'b1;
      if (brk_last)
        brk_pend <= 1'b0;
      else if (brk_req)
        brk_pend <= 1'b1;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign din      = din_q;
  assign u2dwr    = (state == S_LOAD);
  assign txbrk    = (state == S_BRK);
  assign fifo_cnt = cnt;
  assign brk_done = brk_done_q;

endmodule
